mem_access_stage: RTL and testbench

- Memory-access pipeline stage; consumes the execute stage's result bundle: aluop, effective address, store data, write-back data/addr/enable.
- Performs lb/lw/sb/sw against the data memory over a req/ack handshake with byte-lane steering and load sign-extension.
- Forwards non-memory results unchanged to write-back.
- Holds the pipeline (stall_req) while a memory transaction is outstanding.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the memory-access stage and dmem.
// master: req/we/be/addr/wdata out, ack/rdata in; slave: the reverse.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_be,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_be,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: lb/lw/sb/sw over dmem req/ack, forwards ALU results.
// Ports: clk/rst, execute bundle (i_*), o_ready, dmem bus (interface),
// write-back (o_valid, w_reg_*, wd), stall_req, o_bus_err, o_misalign.
// Optional macro MEM_ALIGN_CHECK_EN: reject misaligned lw/sw with o_misalign.
module mem_access_stage #(
  parameter int unsigned DMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [7:0]         i_aluop,
  input  logic [31:0]        i_mem_addr,
  input  logic [31:0]        i_store_data,
  input  logic [31:0]        i_w_reg_data,
  input  logic [4:0]         i_w_reg_addr,
  input  logic               i_wd,
  mem_access_stage_if.master dmem,
  output logic               o_valid,
  output logic [31:0]        w_reg_data,
  output logic [4:0]         w_reg_addr,
  output logic               wd,
  output logic               stall_req,
  output logic               o_bus_err,
  output logic               o_misalign
);

  localparam logic [7:0] OP_LB = 8'h20;
  localparam logic [7:0] OP_LW = 8'h23;
  localparam logic [7:0] OP_SB = 8'h28;
  localparam logic [7:0] OP_SW = 8'h2B;
  localparam logic [7:0] TO    = 8'(DMEM_TIMEOUT);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic        ld_q;
  logic        lb_q;
  logic [1:0]  off_q;
  logic [4:0]  wa_q;
  logic        wdl_q;
  logic        ov_q;
  logic [31:0] od_q;
  logic [4:0]  oa_q;
  logic        owd_q;
  logic        err_q;
  logic        mis_q;

  logic        is_lb;
  logic        is_lw;
  logic        is_sb;
  logic        is_sw;
  logic        is_mem;
  logic        misal;
  logic        go_mem;
  logic [7:0]  rbyte;
  logic [31:0] ld_data;

  assign is_lb  = (i_aluop == OP_LB);
  assign is_lw  = (i_aluop == OP_LW);
  assign is_sb  = (i_aluop == OP_SB);
  assign is_sw  = (i_aluop == OP_SW);
  assign is_mem = is_lb | is_lw | is_sb | is_sw;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = (is_lw | is_sw) & (|i_mem_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  // Misaligned word ops complete locally, so they never stall.
  assign go_mem = is_mem & ~misal;

  assign o_ready   = (state_q == IDLE);
  assign stall_req = (state_q == ACCESS)
                   | ((state_q == IDLE) & i_valid & go_mem);

  assign cnt_d   = cnt_q + 8'd1;
  assign rbyte   = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_data = lb_q ? {{24{rbyte[7]}}, rbyte}
                        : dmem.dmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      ld_q    <= 1'b0;
      lb_q    <= 1'b0;
      off_q   <= '0;
      wa_q    <= '0;
      wdl_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oa_q    <= '0;
      owd_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      ov_q  <= 1'b0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (go_mem) begin
              state_q <= ACCESS;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= is_sb | is_sw;
              be_q    <= is_sb ? (4'b0001 << i_mem_addr[1:0])
                               : 4'b1111;
              addr_q  <= {i_mem_addr[31:2], 2'b00};
              wdat_q  <= is_sb ? {4{i_store_data[7:0]}}
                               : i_store_data;
              ld_q    <= is_lb | is_lw;
              lb_q    <= is_lb;
              off_q   <= i_mem_addr[1:0];
              wa_q    <= i_w_reg_addr;
              wdl_q   <= i_wd;
            end else if (misal) begin
              ov_q  <= 1'b1;
              od_q  <= '0;
              oa_q  <= i_w_reg_addr;
              owd_q <= 1'b0;
              mis_q <= 1'b1;
            end else begin
              ov_q  <= 1'b1;
              od_q  <= i_w_reg_data;
              oa_q  <= i_w_reg_addr;
              owd_q <= i_wd;
            end
          end
        end
        ACCESS: begin
          // Ack beats the timeout when both land on the same edge.
          if (dmem.dmem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ov_q    <= 1'b1;
            od_q    <= ld_q ? ld_data : 32'd0;
            oa_q    <= wa_q;
            owd_q   <= ld_q & wdl_q;
          end else if (cnt_d == TO) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ov_q    <= 1'b1;
            od_q    <= '0;
            oa_q    <= wa_q;
            owd_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdat_q;

  assign o_valid    = ov_q;
  assign w_reg_data = od_q;
  assign w_reg_addr = oa_q;
  assign wd         = owd_q;
  assign o_bus_err  = err_q;
  assign o_misalign = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level model,
// a per-cycle compare process and directed literal checks.
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_aluop;
  logic [31:0] i_mem_addr;
  logic [31:0] i_store_data;
  logic [31:0] i_w_reg_data;
  logic [4:0]  i_w_reg_addr;
  logic        i_wd;
  logic        o_valid;
  logic [31:0] w_reg_data;
  logic [4:0]  w_reg_addr;
  logic        wd;
  logic        stall_req;
  logic        o_bus_err;
  logic        o_misalign;

  mem_access_stage_if bus ();

  mem_access_stage #(.DMEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_aluop     (i_aluop),
    .i_mem_addr  (i_mem_addr),
    .i_store_data(i_store_data),
    .i_w_reg_data(i_w_reg_data),
    .i_w_reg_addr(i_w_reg_addr),
    .i_wd        (i_wd),
    .dmem        (bus),
    .o_valid     (o_valid),
    .w_reg_data  (w_reg_data),
    .w_reg_addr  (w_reg_addr),
    .wd          (wd),
    .stall_req   (stall_req),
    .o_bus_err   (o_bus_err),
    .o_misalign  (o_misalign)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // Responder controls: force_lat -1 random, 0 never ack, k ack in k-th cycle.
  int          force_lat = -1;
  bit          force_rd_en = 0;
  logic [31:0] force_rd = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [7:0] op);
    return op == 8'h20 || op == 8'h23 || op == 8'h28 || op == 8'h2B;
  endfunction

  function automatic bit is_misal(input logic [7:0] op,
                                  input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (op == 8'h23 || op == 8'h2B) && a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Memory responder.
  initial begin
    int rc;
    int lat;
    int r;
    rc = 0;
    lat = 1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.dmem_req) begin
        bus.dmem_ack = 1'b0;
        rc = 0;
      end else begin
        rc++;
        if (rc == 1) begin
          if (force_lat >= 0) lat = force_lat;
          else begin
            r = int'($urandom_range(0, 19));
            if (r == 0) lat = 0;
            else if (r == 1) lat = TO;
            else lat = 1 + (r % 4);
          end
        end
        bus.dmem_ack = (lat != 0) && (rc == lat);
        bus.dmem_rdata = force_rd_en ? force_rd : $urandom;
      end
    end
  end

  // Transaction-level model: one pending memory op, outcome per edge.
  bit          m_busy = 0;
  int          m_cnt = 0;
  logic [7:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_sd;
  logic [4:0]  m_wa;
  logic        m_wd;
  bit          e_valid = 0;
  logic [31:0] e_data;
  logic [4:0]  e_wa;
  logic        e_wd;
  bit          e_err = 0;
  bit          e_mis = 0;
  bit          e_cd = 0;
  bit          e_ca = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] b;
    if (rst) begin
      m_busy = 0;
      e_valid = 0;
      e_err = 0;
      e_mis = 0;
    end else begin
      e_valid = 0;
      e_err = 0;
      e_mis = 0;
      if (m_busy) begin
        if (bus.dmem_ack) begin
          e_valid = 1;
          m_busy = 0;
          if (m_op == 8'h20 || m_op == 8'h23) begin
            b = 8'(bus.dmem_rdata >> (8 * int'(m_addr[1:0])));
            e_data = (m_op == 8'h23) ? bus.dmem_rdata
                                     : 32'($signed(b));
            e_wd = m_wd;
            e_wa = m_wa;
            e_cd = 1;
            e_ca = 1;
          end else begin
            e_data = 0;
            e_wd = 0;
            e_cd = 1;
            e_ca = 0;
          end
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin
            e_valid = 1;
            e_wd = 0;
            e_err = 1;
            e_cd = 0;
            e_ca = 0;
            m_busy = 0;
          end
        end
      end else if (i_valid) begin
        if (!is_mem(i_aluop)) begin
          e_valid = 1;
          e_data = i_w_reg_data;
          e_wa = i_w_reg_addr;
          e_wd = i_wd;
          e_cd = 1;
          e_ca = 1;
        end else if (is_misal(i_aluop, i_mem_addr)) begin
          e_valid = 1;
          e_wd = 0;
          e_mis = 1;
          e_cd = 0;
          e_ca = 0;
        end else begin
          m_busy = 1;
          m_cnt = 0;
          m_op = i_aluop;
          m_addr = i_mem_addr;
          m_sd = i_store_data;
          m_wa = i_w_reg_addr;
          m_wd = i_wd;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [3:0]  xbe;
    logic [31:0] xwd;
    bit          st;
    if (!rst && chk_on) begin
      chk("o_ready", o_ready, m_busy ? 0 : 1);
      chk("dmem_req", bus.dmem_req, m_busy);
      st = m_busy || (i_valid && is_mem(i_aluop)
                      && !is_misal(i_aluop, i_mem_addr));
      chk("stall_req", stall_req, st);
      if (m_busy) begin
        xbe = (m_op == 8'h28) ? 4'(1 << m_addr[1:0]) : 4'hF;
        xwd = (m_op == 8'h28) ? {4{m_sd[7:0]}} : m_sd;
        chk("dmem_addr", bus.dmem_addr, {m_addr[31:2], 2'b00});
        chk("dmem_be", bus.dmem_be, xbe);
        chk("dmem_we", bus.dmem_we,
            (m_op == 8'h28 || m_op == 8'h2B) ? 1 : 0);
        if (m_op == 8'h28 || m_op == 8'h2B)
          chk("dmem_wdata", bus.dmem_wdata, xwd);
      end
      chk("o_valid", o_valid, e_valid);
      if (e_valid) begin
        chk("wd", wd, e_wd);
        chk("o_bus_err", o_bus_err, e_err);
        chk("o_misalign", o_misalign, e_mis);
        if (e_cd) chk("w_reg_data", w_reg_data, e_data);
        if (e_ca) chk("w_reg_addr", w_reg_addr, e_wa);
      end else begin
        chk("o_bus_err_idle", o_bus_err, 0);
        chk("o_misalign_idle", o_misalign, 0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!o_ready && n < 60) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!o_ready) chk("wait_idle_bound", 0, 1);
  endtask

  task automatic run_op(
    input  logic [7:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] sd,
    input  logic [31:0] wdat,
    input  logic [4:0]  wa,
    input  logic        wdi,
    output int          st,
    output int          rq,
    output logic [31:0] rd,
    output logic        rwd,
    output logic        er,
    output logic        ms,
    output logic [3:0]  be,
    output logic [31:0] wdo,
    output logic [31:0] ad
  );
    int n;
    bit gotv;
    wait_idle();
    i_valid = 1'b1;
    i_aluop = op;
    i_mem_addr = a;
    i_store_data = sd;
    i_w_reg_data = wdat;
    i_w_reg_addr = wa;
    i_wd = wdi;
    #1;
    st = stall_req ? 1 : 0;
    rq = 0;
    rd = '0;
    rwd = 1'b0;
    er = 1'b0;
    ms = 1'b0;
    be = '0;
    wdo = '0;
    ad = '0;
    n = 0;
    gotv = 0;
    while (n < 40 && !gotv) begin
      @(posedge clk);
      #2;
      i_valid = 1'b0;
      #1;
      n++;
      if (stall_req) st++;
      if (bus.dmem_req) begin
        rq++;
        be = bus.dmem_be;
        wdo = bus.dmem_wdata;
        ad = bus.dmem_addr;
      end
      if (o_valid) begin
        gotv = 1;
        rd = w_reg_data;
        rwd = wd;
        er = o_bus_err;
        ms = o_misalign;
      end
    end
    if (!gotv) chk("op_complete_bound", 0, 1);
  endtask

  initial begin
    int          st;
    int          rq;
    int          vc;
    logic [31:0] rd;
    logic        rwd;
    logic        er;
    logic        ms;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic [31:0] ad;
    logic [7:0]  op;
    logic [31:0] a;
    int          k;

    rst = 1'b1;
    i_valid = 1'b0;
    i_aluop = '0;
    i_mem_addr = '0;
    i_store_data = '0;
    i_w_reg_data = '0;
    i_w_reg_addr = '0;
    i_wd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_ready", o_ready, 1);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_stall", stall_req, 0);
    #1;
    rst = 1'b0;
    chk_on = 1;
    @(posedge clk);
    #3;

    // Non-memory forward.
    run_op(8'h21, 32'h0, 32'h0, 32'h12345678, 5'd3, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
    chk("fwd_data", rd, 32'h12345678);
    chk("fwd_wd", rwd, 1);
    chk("fwd_req", rq, 0);
    chk("fwd_stall", st, 0);

    // sb, ack in second req cycle.
    force_lat = 2;
    run_op(8'h28, 32'h1002, 32'hAABBCCDD, 32'h0, 5'd4, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
    chk("sb_be", be, 4'b0100);
    chk("sb_wdata", wdo, 32'hDDDDDDDD);
    chk("sb_addr", ad, 32'h1000);
    chk("sb_stall_cycles", st, 3);
    chk("sb_wd", rwd, 0);

    // lb with ack in the first req cycle.
    force_lat = 1;
    force_rd_en = 1;
    force_rd = 32'h80112233;
    run_op(8'h20, 32'h2003, 32'h0, 32'h0, 5'd5, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
    chk("lb3_data", rd, 32'hFFFFFF80);
    chk("lb3_wd", rwd, 1);
    run_op(8'h20, 32'h2001, 32'h0, 32'h0, 5'd6, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
    chk("lb1_data", rd, 32'h00000022);
    force_rd_en = 0;

    // lw with no ack: timeout abort.
    force_lat = 0;
    run_op(8'h23, 32'h4000, 32'h0, 32'h0, 5'd7, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
    chk("to_req_cycles", rq, TO);
    chk("to_bus_err", er, 1);
    chk("to_wd", rwd, 0);
    chk("to_ready", o_ready, 1);

    // Async reset during an outstanding lw.
    wait_idle();
    i_valid = 1'b1;
    i_aluop = 8'h23;
    i_mem_addr = 32'h5000;
    i_w_reg_addr = 5'd8;
    i_wd = 1'b1;
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("ar_req_before", bus.dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("ar_req_dropped", bus.dmem_req, 0);
    chk("ar_ready", o_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (o_valid) vc++;
    end
    chk("ar_no_valid", vc, 0);
    chk("ar_ready_after", o_ready, 1);

    // Word store at misaligned address.
    force_lat = 1;
    run_op(8'h2B, 32'h3001, 32'hCAFEF00D, 32'h0, 5'd9, 1'b1,
           st, rq, rd, rwd, er, ms, be, wdo, ad);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req", rq, 0);
    chk("mis_flag", ms, 1);
    chk("mis_wd", rwd, 0);
    chk("mis_stall", st, 0);
`else
    chk("sw_addr", ad, 32'h3000);
    chk("sw_be", be, 4'b1111);
    chk("sw_wdata", wdo, 32'hCAFEF00D);
    chk("sw_flag", ms, 0);
`endif

    // Randomized traffic, back-to-back issue when o_valid pulses.
    force_lat = -1;
    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0: op = 8'h20;
        1: op = 8'h23;
        2: op = 8'h28;
        3: op = 8'h2B;
        default: begin
          op = 8'($urandom);
          if (is_mem(op)) op = 8'h21;
        end
      endcase
      a = $urandom;
      run_op(op, a, $urandom, $urandom, 5'($urandom), 1'($urandom),
             st, rq, rd, rwd, er, ms, be, wdo, ad);
    end

    wait_idle();
    @(posedge clk);
    #3;
    chk("end_ready", o_ready, 1);
    chk("end_req", bus.dmem_req, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
